// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb, 4 cycles ALU, 5 load/store plus ack waits.
// Stalls on imem/dmem ack with a bus timeout to ERR; perf counters need SEQ_PERF_CNT_EN.
module core_sequencer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic             ir_we,
   input  logic             is_load,
   input  logic             is_store,
   input  logic             is_halt,
   input  logic             reg_we,
   input  logic             br_taken,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             wb_sel,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             retire,
   output logic             halted,
   output logic             error,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   localparam int             TO_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

   state_t          state_q, state_d;
   logic            load_q, load_d;
   logic            store_q, store_d;
   logic            regwe_q, regwe_d;
   logic            br_q, br_d;
   logic [TO_W-1:0] to_q, to_d, to_inc;
   logic            timed_out;

   // Saturating wait counter; an ack in the limit cycle still wins over the timeout.
   assign to_inc    = (to_q == '1) ? to_q : to_q + 1'b1;
   assign timed_out = (MEM_TIMEOUT != 0) && (to_q == TO_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         load_q  <= 1'b0;
         store_q <= 1'b0;
         regwe_q <= 1'b0;
         br_q    <= 1'b0;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         store_q <= store_d;
         regwe_q <= regwe_d;
         br_q    <= br_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      store_d = store_q;
      regwe_d = regwe_q;
      br_d    = br_q;
      to_d    = '0;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH: begin
            if (imem_ack)       state_d = S_DECODE;
            else if (timed_out) state_d = S_ERR;
            else                to_d    = to_inc;
         end
         S_DECODE: begin
            load_d  = is_load;
            store_d = is_store;
            regwe_d = reg_we;
            if (is_halt)                  state_d = S_HALT;
            else if (is_load && is_store) state_d = S_ERR;
            else                          state_d = S_EXEC;
         end
         S_EXEC: begin
            br_d    = br_taken;
            state_d = (load_q || store_q) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (dmem_ack)       state_d = S_WB;
            else if (timed_out) state_d = S_ERR;
            else                to_d    = to_inc;
         end
         S_WB:     state_d = run ? S_FETCH : S_IDLE;
         default:  state_d = state_q;
      endcase
   end

   // Reset forces every output low in the same cycle, even mid-access.
   always_comb begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      mdr_we   = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      retire   = 1'b0;
      halted   = 1'b0;
      error    = 1'b0;
      state_o  = 3'd0;
      if (!rst) begin
         state_o = state_q;
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ack;
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = store_q;
               mdr_we   = dmem_ack && load_q;
            end
            S_WB: begin
               rf_we  = regwe_q;
               wb_sel = load_q;
               pc_we  = 1'b1;
               pc_sel = br_q;
               retire = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_ERR:   error  = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q, ret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         if (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB}) cyc_q <= cyc_q + 1'b1;
         if (state_q == S_WB) ret_q <= ret_q + 1'b1;
      end
   end

   assign cycle_cnt   = cyc_q;
   assign instret_cnt = ret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule
